// File: rtl/ws2812_chain_ctrl.sv
// WS2812 chain frame scheduler: per-LED colour registers, brightness scaling,
// rate-limited GRB/MSB-first bit streaming over valid/ready, then latch gap.
module ws2812_chain_ctrl #(
    parameter int NUM_LEDS   = 4,
    parameter int ADDR_W     = 2,
    parameter int CLK_FRE    = 48_000_000,
    parameter int REFRESH_HZ = 100,
    parameter int RESET_US   = 80
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic [7:0]        brightness,
    output logic              bit_valid,
    output logic              bit_data,
    input  logic              bit_ready,
    output logic              busy,
    output logic              frame_done
);

    localparam int PERIOD_CYC = CLK_FRE / REFRESH_HZ;
    localparam int RESET_CYC  = (CLK_FRE / 1_000_000) * RESET_US;
    localparam int PER_W      = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int LAT_W      = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;
    localparam int RAM_DEPTH  = 1 << ADDR_W;

    localparam logic [PER_W-1:0]  PER_MAX    = PER_W'(PERIOD_CYC - 1);
    localparam logic [PER_W-1:0]  PER_ONE    = PER_W'(1);
    localparam logic [LAT_W-1:0]  LAT_LAST   = LAT_W'(RESET_CYC - 1);
    localparam logic [LAT_W-1:0]  LAT_PRE    = LAT_W'((RESET_CYC > 1) ? RESET_CYC - 2 : 0);
    localparam logic [LAT_W-1:0]  LAT_ONE    = LAT_W'(1);
    localparam logic [ADDR_W-1:0] IDX_LAST   = ADDR_W'(NUM_LEDS - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W:0]   NUM_LEDS_W = (ADDR_W + 1)'(NUM_LEDS);
    localparam logic              LAT_SINGLE = (RESET_CYC == 1) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    // (ch * (bri + 1)) >> 8 on a 16-bit product; bri = 255 passes ch unchanged
    function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [7:0] bri);
        logic [15:0] prod;
        prod = {8'd0, ch} * ({8'd0, bri} + 16'd1);
        return prod[15:8];
    endfunction

    state_t            state_r;
    logic              dirty_r;
    logic [PER_W-1:0]  period_cnt_r;
    logic [LAT_W-1:0]  latch_cnt_r;
    logic [7:0]        bri_q_r;
    logic [ADDR_W-1:0] idx_r;
    logic [4:0]        bitcnt_r;
    logic [23:0]       shreg_r;
    logic [23:0]       ram_r [RAM_DEPTH];

    logic              wr_hit_s;
    logic              transfer_s;
    logic [23:0]       led_s;
    logic [23:0]       grb_s;

    // Write qualification, handshake and scaled GRB word for the LED being loaded
    always_comb begin
        wr_hit_s   = 1'b0;
        transfer_s = 1'b0;
        led_s      = 24'd0;
        grb_s      = 24'd0;
        if (wr_en && ({1'b0, wr_addr} < NUM_LEDS_W)) begin
            wr_hit_s = 1'b1;
        end else begin
            wr_hit_s = 1'b0;
        end
        transfer_s = bit_valid & bit_ready;
        led_s      = ram_r[idx_r];
        grb_s      = {scale_ch(led_s[15:8], bri_q_r),
                      scale_ch(led_s[23:16], bri_q_r),
                      scale_ch(led_s[7:0], bri_q_r)};
    end

    // Colour register file; out-of-range addresses are dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RAM_DEPTH; i++) begin
                ram_r[i] <= 24'd0;
            end
        end else if (wr_hit_s) begin
            ram_r[wr_addr] <= wr_data;
        end
    end

    // Frame scheduler: rate limit, per-LED load, bit shifting and latch gap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            dirty_r      <= 1'b1;
            period_cnt_r <= PER_MAX;
            latch_cnt_r  <= {LAT_W{1'b0}};
            bri_q_r      <= 8'd0;
            idx_r        <= {ADDR_W{1'b0}};
            bitcnt_r     <= 5'd0;
            shreg_r      <= 24'd0;
            bit_valid    <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            if (period_cnt_r != PER_MAX) begin
                period_cnt_r <= period_cnt_r + PER_ONE;
            end
            if (wr_hit_s) begin
                dirty_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (dirty_r && (period_cnt_r == PER_MAX)) begin
                        // a write landing on the start cycle keeps the chain dirty
                        dirty_r      <= wr_hit_s;
                        bri_q_r      <= brightness;
                        idx_r        <= {ADDR_W{1'b0}};
                        period_cnt_r <= {PER_W{1'b0}};
                        busy         <= 1'b1;
                        state_r      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    shreg_r   <= grb_s;
                    bitcnt_r  <= 5'd23;
                    bit_valid <= 1'b1;
                    state_r   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (transfer_s) begin
                        shreg_r  <= {shreg_r[22:0], 1'b0};
                        bitcnt_r <= bitcnt_r - 5'd1;
                        if (bitcnt_r == 5'd0) begin
                            bit_valid <= 1'b0;
                            if (idx_r == IDX_LAST) begin
                                latch_cnt_r <= {LAT_W{1'b0}};
                                frame_done  <= LAT_SINGLE;
                                state_r     <= ST_LATCH;
                            end else begin
                                idx_r   <= idx_r + IDX_ONE;
                                state_r <= ST_LOAD;
                            end
                        end
                    end
                end
                ST_LATCH: begin
                    if (latch_cnt_r == LAT_LAST) begin
                        frame_done <= 1'b0;
                        busy       <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else begin
                        latch_cnt_r <= latch_cnt_r + LAT_ONE;
                        frame_done  <= (latch_cnt_r == LAT_PRE);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bit_data = shreg_r[23];

endmodule

// File: tb/tb_ws2812_chain_ctrl.sv
// Directed bench for ws2812_chain_ctrl: 4-LED instance for streaming checks,
// 3-LED instance for rate-limit spacing and out-of-range write handling.
module tb_ws2812_chain_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reset_n, wr_en, bit_valid, bit_data, bit_ready, busy, frame_done;
    logic [1:0]  wr_addr;
    logic [23:0] wr_data;
    logic [7:0]  brightness;

    logic        rst3_n, wr_en3, bit_valid3, bit_data3, bit_ready3, busy3, frame_done3;
    logic [1:0]  wr_addr3;
    logic [23:0] wr_data3;
    logic [7:0]  bri3;

    ws2812_chain_ctrl #(.NUM_LEDS(4), .ADDR_W(2), .CLK_FRE(1_000_000),
                        .REFRESH_HZ(10_000), .RESET_US(10)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .brightness(brightness), .bit_valid(bit_valid),
        .bit_data(bit_data), .bit_ready(bit_ready), .busy(busy),
        .frame_done(frame_done));

    ws2812_chain_ctrl #(.NUM_LEDS(3), .ADDR_W(2), .CLK_FRE(1_000_000),
                        .REFRESH_HZ(10_000), .RESET_US(10)) dut3 (
        .clk(clk), .reset_n(rst3_n), .wr_en(wr_en3), .wr_addr(wr_addr3),
        .wr_data(wr_data3), .brightness(bri3), .bit_valid(bit_valid3),
        .bit_data(bit_data3), .bit_ready(bit_ready3), .busy(busy3),
        .frame_done(frame_done3));

    int n_checks = 0;
    int n_fail   = 0;

    logic [95:0] cap_bits;
    int          cap_ntx, cap_busy, cap_herr, cap_start;
    bit          cap_to;
    int          sch_at [2];
    logic [1:0]  sch_addr [2];
    logic [23:0] sch_data [2];

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write4(input logic [1:0] a, input logic [23:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic write3(input logic [1:0] a, input logic [23:0] d);
        @(negedge clk);
        wr_en3 = 1'b1; wr_addr3 = a; wr_data3 = d;
        @(negedge clk);
        wr_en3 = 1'b0;
    endtask

    // Records one frame of the 4-LED instance, issuing scheduled writes mid-frame
    task automatic capture(input bit toggle);
        int guard;
        bit hold_pend, done1, done2;
        logic hold_bit;
        cap_bits = '0; cap_ntx = 0; cap_busy = 0; cap_herr = 0; cap_start = -1; cap_to = 1'b1;
        hold_pend = 1'b0; hold_bit = 1'b0; done1 = 1'b0; done2 = 1'b0; guard = 0;
        while (busy !== 1'b1 && guard < 400) begin @(negedge clk); guard++; end
        if (busy === 1'b1) begin
            cap_start = cyc;
            guard = 0;
            while (guard < 3000) begin
                if (toggle) bit_ready = ~bit_ready;
                if (busy === 1'b1) cap_busy++;
                if (hold_pend && (bit_valid !== 1'b1 || bit_data !== hold_bit)) cap_herr++;
                hold_pend = (bit_valid === 1'b1) && (bit_ready === 1'b0);
                hold_bit  = bit_data;
                if (bit_valid === 1'b1 && bit_ready === 1'b1) begin
                    cap_bits = {cap_bits[94:0], bit_data};
                    cap_ntx++;
                end
                if (frame_done === 1'b1) begin cap_to = 1'b0; break; end
                wr_en = 1'b0;
                if (!done1 && sch_at[0] >= 0 && cap_ntx >= sch_at[0]) begin
                    wr_en = 1'b1; wr_addr = sch_addr[0]; wr_data = sch_data[0]; done1 = 1'b1;
                end else if (!done2 && sch_at[1] >= 0 && cap_ntx >= sch_at[1]) begin
                    wr_en = 1'b1; wr_addr = sch_addr[1]; wr_data = sch_data[1]; done2 = 1'b1;
                end
                @(negedge clk);
                guard++;
            end
        end
        wr_en = 1'b0; bit_ready = 1'b1; sch_at[0] = -1; sch_at[1] = -1;
    endtask

    task automatic run_frame(input string tag, input bit toggle, input logic [95:0] exp);
        capture(toggle);
        check({tag, "_timeout"}, cap_to, 0);
        check({tag, "_bits"}, cap_bits, exp);
        check({tag, "_ntx"}, cap_ntx, 96);
        if (toggle) check({tag, "_hold"}, cap_herr, 0);
        else        check({tag, "_busy_len"}, cap_busy, 110);
        @(negedge clk);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_done_after"}, frame_done, 0);
    endtask

    task automatic count_busy4(input int n, output int nb);
        nb = 0;
        repeat (n) begin @(negedge clk); if (busy !== 1'b0) nb++; end
    endtask

    task automatic wait3(input logic lvl, input string tag);
        int guard;
        guard = 0;
        while (busy3 !== lvl && guard < 400) begin @(negedge clk); guard++; end
        check(tag, (busy3 === lvl), 1);
    endtask

    initial begin
        int nb, t1, t2, ts_a, guard;
        sch_at[0] = -1; sch_at[1] = -1;
        sch_addr[0] = 2'd0; sch_addr[1] = 2'd0; sch_data[0] = 24'd0; sch_data[1] = 24'd0;
        reset_n = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 24'd0;
        brightness = 8'hFF; bit_ready = 1'b1;
        rst3_n = 1'b0; wr_en3 = 1'b0; wr_addr3 = 2'd0; wr_data3 = 24'd0;
        bri3 = 8'hFF; bit_ready3 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_bit_valid", bit_valid, 0);
        check("rst_bit_data", bit_data, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst3_outputs", {bit_valid3, bit_data3, busy3, frame_done3}, 0);

        // Reset release: all-off frame, then silence
        reset_n = 1'b1; rst3_n = 1'b1;
        run_frame("boot", 1'b0, 96'h0);
        count_busy4(250, nb);
        check("no_refresh_idle", nb, 0);

        // Single LED write, full brightness
        write4(2'd1, 24'h123456);
        run_frame("led1", 1'b0, {24'h000000, 24'h341256, 24'h000000, 24'h000000});

        // Half brightness, then zero brightness
        brightness = 8'h7F;
        write4(2'd0, 24'hFF8040);
        run_frame("bri7f", 1'b0, {24'h407F20, 24'h1A092B, 24'h000000, 24'h000000});
        brightness = 8'h00;
        write4(2'd0, 24'hFF8040);
        run_frame("bri0", 1'b0, 96'h0);
        brightness = 8'h40;
        count_busy4(200, nb);
        check("bri_only_no_frame", nb, 0);

        // Back-pressure: ready toggling every cycle
        brightness = 8'hFF;
        write4(2'd2, 24'hA5C3F0);
        run_frame("toggle", 1'b1, {24'h80FF40, 24'h341256, 24'hC3A5F0, 24'h000000});

        // Writes during the frame: LED3 lands in this frame, LED0 forces another
        sch_at[0] = 50; sch_addr[0] = 2'd3; sch_data[0] = 24'h0000FF;
        sch_at[1] = 60; sch_addr[1] = 2'd0; sch_data[1] = 24'h102030;
        write4(2'd1, 24'h00FF00);
        run_frame("midwr_a", 1'b0, {24'h80FF40, 24'hFF0000, 24'hC3A5F0, 24'h0000FF});
        ts_a = cap_start;
        run_frame("midwr_b", 1'b0, {24'h201030, 24'hFF0000, 24'hC3A5F0, 24'h0000FF});
        check("midwr_spacing", cap_start - ts_a, 111);

        // Asynchronous reset in the middle of SHIFT
        write4(2'd0, 24'hFFFFFF);
        guard = 0;
        while (busy !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
        check("mid_rst_start", busy, 1);
        repeat (5) @(negedge clk);
        check("mid_rst_pre_valid", bit_valid, 1);
        check("mid_rst_pre_data", bit_data, 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", bit_valid, 0);
        check("mid_rst_data", bit_data, 0);
        check("mid_rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_frame("post_rst", 1'b0, 96'h0);

        // 3-LED instance: frame starts spaced by the refresh period
        write3(2'd0, 24'h010101);
        @(negedge clk);
        check("sp_first_start", busy3, 1);
        t1 = cyc;
        repeat (3) @(negedge clk);
        write3(2'd1, 24'h020202);
        wait3(1'b0, "sp_first_end");
        wait3(1'b1, "sp_second_start");
        t2 = cyc;
        check("sp_spacing", t2 - t1, 100);
        wait3(1'b0, "sp_second_end");

        // 3-LED instance: out-of-range address ignored
        repeat (150) @(negedge clk);
        write3(2'd3, 24'hFFFFFF);
        nb = 0;
        repeat (300) begin @(negedge clk); if (busy3 !== 1'b0) nb++; end
        check("oob_no_frame", nb, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
